decode_ctrl: RTL and testbench

- Sequencer for the classification index decoder, which is a 10-deep signed score shift register with an argmax (first maximum wins).
- On `start`, the block fetches N_CLASS signed scores from the shared feature/score memory through a request/grant read port.
- It pushes each score into the decoder with its enable, then latches the resulting class index and reports `done`.
- It sits between the top-level CNN control FSM and the decoder.

---
 rtl/decode_ctrl_if.sv | 24 ++
 rtl/decode_ctrl.sv | 117 +++++++++++
 tb/tb_decode_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_if.sv
// Memory read port and decoder push/result signals shared by the decode sequencer.
// The master side is the controller; the slave side is the memory and decoder pair.
interface decode_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [DATA_W-1:0] mem_rdata;
    logic              dec_en;
    logic [DATA_W-1:0] dec_data;
    logic [DATA_W-1:0] dec_index;

    modport master (
        output mem_rd, mem_addr, dec_en, dec_data,
        input  mem_gnt, mem_rdata, dec_index
    );

    modport slave (
        input  mem_rd, mem_addr, dec_en, dec_data,
        output mem_gnt, mem_rdata, dec_index
    );
endinterface

// File: rtl/decode_ctrl.sv
// Sequencer that fetches N_CLASS scores from memory, streams them into the
// argmax decoder and latches the winning class index.
module decode_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int N_CLASS = 10,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    decode_ctrl_if.master     bus
);
    localparam int CNT_W = $clog2(N_CLASS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(N_CLASS - 1);
    localparam logic [CNT_W-1:0] ALL_PUSHED = CNT_W'(N_CLASS);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, LATCH, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  push_cnt;
    logic              mem_rd_q;
    logic              rd_vld;
    logic              taken;
    logic              push_last;
    logic              unused_index_bits;

    assign taken         = mem_rd_q & bus.mem_gnt;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.dec_en    = rd_vld;
    assign bus.dec_data  = rd_vld ? bus.mem_rdata : '0;
    assign unused_index_bits = ^bus.dec_index[DATA_W-1:IDX_W];

    // DRAIN may leave in the same cycle the final push is being clocked in,
    // so the decoder is fully loaded by the time LATCH samples it.
    assign push_last = (push_cnt == ALL_PUSHED) ||
                       (rd_vld && (push_cnt == ALL_PUSHED - CNT_ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld   <= 1'b0;
            push_cnt <= '0;
        end else begin
            rd_vld <= taken;
            if (state == IDLE && start) begin
                push_cnt <= '0;
            end else if (rd_vld) begin
                push_cnt <= push_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base_q     <= '0;
            mem_addr_q <= '0;
            issue_cnt  <= '0;
            mem_rd_q   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        mem_addr_q <= base_addr;
                        issue_cnt  <= '0;
                        class_idx  <= '0;
                        mem_rd_q   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (taken) begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                        if (issue_cnt == LAST_ISSUE) begin
                            mem_rd_q   <= 1'b0;
                            mem_addr_q <= '0;
                            state      <= DRAIN;
                        end else begin
                            // Address wraps modulo 2^ADDR_W by construction.
                            mem_addr_q <= base_q + ADDR_W'(issue_cnt + CNT_ONE);
                        end
                    end
                end
                DRAIN: begin
                    if (push_last) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    class_idx <= bus.dec_index[IDX_W-1:0];
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: stimulus queues expected reads, pushes and
// results; a negedge monitor pops and compares as the DUT produces them.
module tb_decode_ctrl;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 16;
    localparam int N_CLASS = 10;
    localparam int IDX_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  class_idx;

    decode_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    decode_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CLASS(N_CLASS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .class_idx(class_idx), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [ADDR_W-1:0] addr; int cyc; } rd_t;
    typedef struct { logic [DATA_W-1:0] data; int cyc; } push_t;
    typedef struct { logic [IDX_W-1:0]  idx;  int cyc; } run_t;

    rd_t   rd_q[$];
    push_t push_q[$];
    run_t  run_q[$];
    rd_t   mon_rd;
    push_t mon_push;
    run_t  mon_run;

    logic [DATA_W-1:0] mem [0:65535];
    logic [DATA_W-1:0] sc [N_CLASS];
    int t0       = 0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    int stall_lo = -1;
    int stall_hi = -1;

    // Memory slave: grant follows the stall window, data returns one cycle later.
    assign bus.mem_gnt = !(cyc >= stall_lo && cyc <= stall_hi);

    always @(posedge clk) begin
        if (bus.mem_rd && bus.mem_gnt) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Decoder: push i settles at slot i; first maximum wins.
    logic signed [DATA_W-1:0] dq [N_CLASS];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CLASS; k++) dq[k] <= '0;
        end else if (bus.dec_en) begin
            for (int k = 0; k < N_CLASS - 1; k++) dq[k] <= dq[k+1];
            dq[N_CLASS-1] <= bus.dec_data;
        end
    end

    always_comb begin : argmax
        int best_k;
        logic signed [DATA_W-1:0] best;
        best_k = 0;
        best   = dq[0];
        for (int k = 1; k < N_CLASS; k++) begin
            if (dq[k] > best) begin
                best   = dq[k];
                best_k = k;
            end
        end
        bus.dec_index = 32'(best_k);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_dec_en", 32'(bus.dec_en), 32'd0);
        checkOutput("rst_dec_data", bus.dec_data, 32'd0);
        checkOutput("rst_class_idx", 32'(class_idx), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_rd && bus.mem_gnt) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rd_extra: got read at %0h, expected no read (cycle %0d)", bus.mem_addr, cyc);
                end else begin
                    mon_rd = rd_q.pop_front();
                    checkOutput("rd_addr", 32'(bus.mem_addr), 32'(mon_rd.addr));
                    checkOutput("rd_cycle", cyc, mon_rd.cyc);
                end
            end
            if (bus.dec_en) begin
                if (push_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL push_extra: got push %0h, expected no push (cycle %0d)", bus.dec_data, cyc);
                end else begin
                    mon_push = push_q.pop_front();
                    checkOutput("push_data", bus.dec_data, mon_push.data);
                    checkOutput("push_cycle", cyc, mon_push.cyc);
                end
            end else begin
                checkOutput("dec_data_idle", bus.dec_data, 32'd0);
            end
            if (done) begin
                if (run_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL done_extra: got done idx %0d, expected no done (cycle %0d)", class_idx, cyc);
                end else begin
                    mon_run = run_q.pop_front();
                    checkOutput("class_idx", 32'(class_idx), 32'(mon_run.idx));
                    checkOutput("done_cycle", cyc, mon_run.cyc);
                end
            end
            checkOutput("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // Called one step after a rising edge; that cycle becomes cycle 0 of the run.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int stall,
                                 input logic [IDX_W-1:0] exp_idx, input int done_rel);
        logic [ADDR_W-1:0] a;
        int rel;
        t0 = cyc;
        for (int i = 0; i < N_CLASS; i++) begin
            a = base + ADDR_W'(i);
            mem[a] = sc[i];
            rel = i + 1 + ((stall != 0 && i >= 4) ? 3 : 0);
            rd_q.push_back('{a, t0 + rel});
            push_q.push_back('{sc[i], t0 + rel + 1});
        end
        if (stall != 0) begin
            stall_lo = t0 + 5;
            stall_hi = t0 + 7;
        end else begin
            stall_lo = -1;
            stall_hi = -1;
        end
        run_q.push_back('{exp_idx, t0 + done_rel});
        busy_lo   = t0 + 1;
        busy_hi   = t0 + done_rel;
        base_addr = base;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("idx_cleared", 32'(class_idx), 32'd0);
    endtask

    task automatic waitRel(input int r);
        while (cyc - t0 < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input logic [IDX_W-1:0] hold_idx);
        for (int n = 0; n < 200 && (run_q.size() != 0 || rd_q.size() != 0 || push_q.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pending_runs", 32'(run_q.size()), 32'd0);
        checkOutput("pending_reads", 32'(rd_q.size()), 32'd0);
        checkOutput("pending_pushes", 32'(push_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idx_held", 32'(class_idx), 32'(hold_idx));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkReset();
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] continuous grant");
        sc = '{32'sd5, -32'sd3, 32'sd7, 32'sd2, 32'sd0, -32'sd1, 32'sd9, 32'sd4, 32'sd1, 32'sd3};
        applyStimulus(16'h0100, 0, 4'd6, 13);
        waitIdle(4'd6);

        $display("[TB] grant stall");
        for (int i = 0; i < N_CLASS; i++) sc[i] = -32'sd5;
        sc[9] = -32'sd2;
        applyStimulus(16'h0700, 1, 4'd9, 16);
        waitRel(6);
        checkOutput("stall_addr", 32'(bus.mem_addr), 32'h0704);
        checkOutput("stall_rd", 32'(bus.mem_rd), 32'd1);
        waitIdle(4'd9);

        $display("[TB] tie resolves low");
        for (int i = 0; i < N_CLASS; i++) sc[i] = 32'sd1;
        sc[0] = 32'sd8;
        sc[1] = 32'sd8;
        applyStimulus(16'h0200, 0, 4'd0, 13);
        waitIdle(4'd0);

        $display("[TB] all most-negative");
        for (int i = 0; i < N_CLASS; i++) sc[i] = 32'h8000_0000;
        applyStimulus(16'h0600, 0, 4'd0, 13);
        waitIdle(4'd0);

        $display("[TB] ignored starts then relaunch");
        for (int i = 0; i < N_CLASS; i++) sc[i] = 32'(i + 1);
        applyStimulus(16'h0300, 0, 4'd9, 13);
        waitRel(5);
        base_addr = 16'h0BAD;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitRel(13);
        start = 1'b1;
        @(posedge clk);
        #1;
        sc = '{32'sd0, 32'sd0, 32'sd0, -32'sd7, 32'sd100, 32'sd100, 32'sd2, 32'sd2, 32'sd2, 32'sd2};
        applyStimulus(16'h0320, 0, 4'd4, 13);
        waitIdle(4'd4);

        $display("[TB] reset mid-read");
        for (int i = 0; i < N_CLASS; i++) sc[i] = 32'sd1000;
        applyStimulus(16'h0400, 0, 4'd0, 13);
        waitRel(6);
        rst = 1'b0;
        #1;
        checkReset();
        rd_q.delete();
        push_q.delete();
        run_q.delete();
        busy_lo = 1;
        busy_hi = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        sc = '{-32'sd9, -32'sd8, -32'sd7, 32'sd20, -32'sd6, -32'sd5, -32'sd4, -32'sd3, -32'sd2, -32'sd1};
        applyStimulus(16'h0500, 0, 4'd3, 13);
        waitIdle(4'd3);

        $display("[TB] address wrap");
        sc = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd60, 32'sd6, 32'sd7, 32'sd8, 32'sd9};
        applyStimulus(16'hFFFC, 0, 4'd5, 13);
        waitIdle(4'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
